full_adder: RTL and testbench

Registered full-adder block: adds operands i1 and i2 plus carry-in cin and produces sum and carry-out.
- WIDTH=1 is the classic single-bit full adder.
- Wider instances form a ripple-carry chain of 1-bit full-adder cells.
- Outputs are registered, so the block sits directly in a synchronous datapath with a valid strobe.

---
 rtl/full_adder_if.sv | 24 ++
 rtl/full_adder.sv | 63 ++++++
 tb/tb_full_adder.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered full adder: operands with their
// valid strobe in one direction, registered results with their valid strobe back.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic             cin;
    logic             in_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             out_valid;

    modport master (
        output i1, i2, cin, in_valid,
        input  sum, cout, ovf, out_valid
    );

    modport slave (
        input  i1, i2, cin, in_valid,
        output sum, cout, ovf, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered ripple-carry adder: {cout, sum} = i1 + i2 + cin with a signed
// overflow flag, one clock of latency and a valid strobe travelling alongside.
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);

    // Carry chain of 1-bit full-adder cells; c[0] is the carry-in.
    function automatic logic [WIDTH:0] ripple_carries(
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             c0
    );
        logic [WIDTH:0] c;
        c[0] = c0;
        for (int k = 0; k < WIDTH; k++) begin
            c[k+1] = (a[k] & b[k]) | (a[k] & c[k]) | (b[k] & c[k]);
        end
        return c;
    endfunction

    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;
    logic             ovf_p0;

    always_comb begin
        carry_p0 = ripple_carries(bus.i1, bus.i2, bus.cin);
        sum_p0   = bus.i1 ^ bus.i2 ^ carry_p0[WIDTH-1:0];
        ovf_p0   = carry_p0[WIDTH] ^ carry_p0[WIDTH-1];
    end

    // ---- stage p0 -> p1: output registers ----
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             ovf_p1;
    logic             vld_p1;

    // Result registers load only on an accepted input, so idle operands never disturb them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            ovf_p1  <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= bus.in_valid;
            if (bus.in_valid) begin
                sum_p1  <= sum_p0;
                cout_p1 <= carry_p0[WIDTH];
                ovf_p1  <= ovf_p0;
            end
        end
    end

    assign bus.sum       = sum_p1;
    assign bus.cout      = cout_p1;
    assign bus.ovf       = ovf_p1;
    assign bus.out_valid = vld_p1;

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH 1, 8 and 16, checked against plain
// integer arithmetic for sum, carry-out and signed overflow.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1))  b1();
    full_adder_if #(.WIDTH(8))  b8();
    full_adder_if #(.WIDTH(16)) b16();

    full_adder #(.WIDTH(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
    full_adder #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8));
    full_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16));

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    // Reference: unsigned sum for {cout,sum}; signed range check for overflow.
    function automatic res_t model(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic c);
        res_t        r;
        logic [64:0] t;
        longint      sa, sb, s, lo, hi;
        t      = {1'b0, a} + {1'b0, b} + {64'd0, c};
        r.sum  = t[63:0] & ((64'd1 << w) - 64'd1);
        r.cout = t[w];
        sa     = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb     = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        s      = sa + sb + longint'(c);
        hi     = (longint'(1) << (w - 1)) - 1;
        lo     = -(longint'(1) << (w - 1));
        r.ovf  = (s > hi) || (s < lo);
        return r;
    endfunction

    task automatic test_reset();
        b1.i1 = 1'b0; b1.i2 = 1'b0; b1.cin = 1'b0; b1.in_valid = 1'b0;
        b8.i1 = '0;   b8.i2 = '0;   b8.cin = 1'b0; b8.in_valid = 1'b0;
        b16.i1 = '0;  b16.i2 = '0;  b16.cin = 1'b0; b16.in_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_w1 got=%b want=0000", {b1.sum, b1.cout, b1.ovf, b1.out_valid});
        end
        checks++;
        if ({b8.sum, b8.cout, b8.ovf, b8.out_valid} !== 11'd0) begin
            errors++;
            $display("FAIL reset_w8 got=%h want=0", {b8.sum, b8.cout, b8.ovf, b8.out_valid});
        end
        checks++;
        if ({b16.sum, b16.cout, b16.ovf, b16.out_valid} !== 19'd0) begin
            errors++;
            $display("FAIL reset_w16 got=%h want=0", {b16.sum, b16.cout, b16.ovf, b16.out_valid});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_truth_table();
        res_t r;
        logic [2:0] prev;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            if (k > 0) begin
                r = model(1, {63'd0, prev[2]}, {63'd0, prev[1]}, prev[0]);
                checks++;
                if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== {r.sum[0], r.cout, r.ovf, 1'b1}) begin
                    errors++;
                    $display("FAIL truth_%b got=%b want=%b", prev,
                             {b1.sum, b1.cout, b1.ovf, b1.out_valid}, {r.sum[0], r.cout, r.ovf, 1'b1});
                end
            end
            if (k < 8) begin
                prev = 3'(k);
                {b1.i1, b1.i2, b1.cin} = prev;
                b1.in_valid = 1'b1;
            end else begin
                b1.in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_reset_dominates();
        {b1.i1, b1.i2, b1.cin} = 3'b111;
        b1.in_valid = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_dominates got=%b want=0000", {b1.sum, b1.cout, b1.ovf, b1.out_valid});
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== 4'b1101) begin
            errors++;
            $display("FAIL reset_release got=%b want=1101", {b1.sum, b1.cout, b1.ovf, b1.out_valid});
        end
    endtask

    task automatic test_hold();
        {b1.i1, b1.i2, b1.cin} = 3'b101;
        b1.in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== 4'b0101) begin
            errors++;
            $display("FAIL hold_load got=%b want=0101", {b1.sum, b1.cout, b1.ovf, b1.out_valid});
        end
        b1.in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            {b1.i1, b1.i2, b1.cin} = 3'(k * 3 + 2);
            @(negedge clk);
            checks++;
            if ({b1.sum, b1.cout, b1.ovf, b1.out_valid} !== 4'b0100) begin
                errors++;
                $display("FAIL hold_%0d got=%b want=0100", k, {b1.sum, b1.cout, b1.ovf, b1.out_valid});
            end
        end
    endtask

    task automatic test_w8_corners();
        logic [7:0] a_t [4] = '{8'hFF, 8'hFF, 8'h7F, 8'h80};
        logic [7:0] b_t [4] = '{8'h01, 8'hFF, 8'h01, 8'h80};
        logic       c_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] s_t [4] = '{8'h00, 8'hFF, 8'h80, 8'h00};
        logic       co_t[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       ov_t[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            b8.i1 = a_t[k]; b8.i2 = b_t[k]; b8.cin = c_t[k]; b8.in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({b8.sum, b8.cout, b8.ovf, b8.out_valid} !== {s_t[k], co_t[k], ov_t[k], 1'b1}) begin
                errors++;
                $display("FAIL w8_corner_%0d got=%h/%b/%b/%b want=%h/%b/%b/1", k,
                         b8.sum, b8.cout, b8.ovf, b8.out_valid, s_t[k], co_t[k], ov_t[k]);
            end
        end
        b8.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({b8.sum, b8.out_valid} !== {8'h00, 1'b0}) begin
            errors++;
            $display("FAIL w8_idle got=%h/%b want=00/0", b8.sum, b8.out_valid);
        end
    endtask

    task automatic test_random_w16();
        res_t exp_r = '0;
        logic prev_vld = 1'b0;
        int   accepted = 0;
        int   pulses = 0;
        for (int n = 0; n <= 1000 || prev_vld; ) begin
            @(negedge clk);
            if (b16.out_valid === 1'b1) pulses++;
            checks++;
            if ({b16.sum, b16.cout, b16.ovf, b16.out_valid} !== {exp_r.sum[15:0], exp_r.cout, exp_r.ovf, prev_vld}) begin
                errors++;
                $display("FAIL rand_w16_%0d got=%h/%b/%b/%b want=%h/%b/%b/%b", n,
                         b16.sum, b16.cout, b16.ovf, b16.out_valid,
                         exp_r.sum[15:0], exp_r.cout, exp_r.ovf, prev_vld);
            end
            b16.i1  = 16'($urandom);
            b16.i2  = 16'($urandom);
            b16.cin = 1'($urandom);
            b16.in_valid = (n < 1000) && ($urandom_range(0, 3) != 0);
            prev_vld = b16.in_valid;
            if (b16.in_valid) begin
                exp_r = model(16, {48'd0, b16.i1}, {48'd0, b16.i2}, b16.cin);
                accepted++;
                n++;
            end else if (n >= 1000) begin
                n++;
            end
        end
        checks++;
        if (pulses !== accepted) begin
            errors++;
            $display("FAIL rand_w16_pulses got=%0d want=%0d", pulses, accepted);
        end
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_reset_dominates();
        test_hold();
        test_w8_corners();
        test_random_w16();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
